// File: rtl/ks_buf_pkg.sv
// Shared types and helpers for the keystream block collector and its banks.
package ks_buf_pkg;

    localparam int unsigned KS_BLOCK_BITS = 512;
    // Wide enough for any block length up to one word per state-matrix bit.
    localparam int unsigned KS_LEN_W      = $clog2(KS_BLOCK_BITS + 1);

    typedef struct packed {
        logic                full;
        logic [KS_LEN_W-1:0] len;
    } bank_state_t;

    function automatic int unsigned next_bank(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/ks_block_collector_if.sv
// Word-in / block-out handshake bundle for ks_block_collector.
// stall_cnt exists only when KSB_STALL_CNT_EN is defined.
interface ks_block_collector_if #(
    parameter int unsigned DATA_W        = 8,
    parameter int unsigned WORDS_PER_BLK = 64,
    parameter int unsigned NUM_BANKS     = 2
) ();
    localparam int unsigned LEN_W = $clog2(WORDS_PER_BLK + 1);
    localparam int unsigned BU_W  = $clog2(NUM_BANKS + 1);

    logic                              in_valid;
    logic [DATA_W-1:0]                 in_data;
    logic                              in_last;
    logic                              in_ready;
    logic                              out_valid;
    logic [DATA_W*WORDS_PER_BLK-1:0]   out_data;
    logic [LEN_W-1:0]                  out_len;
    logic                              out_ready;
    logic [BU_W-1:0]                   banks_used;
`ifdef KSB_STALL_CNT_EN
    logic [15:0]                       stall_cnt;
`endif

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_len, banks_used
`ifdef KSB_STALL_CNT_EN
        , input stall_cnt
`endif
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_len, banks_used
`ifdef KSB_STALL_CNT_EN
        , output stall_cnt
`endif
    );

endinterface

// File: rtl/ks_buf_bank.sv
// One block bank: word storage, length and full flag, zero-masked wide read port.
module ks_buf_bank
    import ks_buf_pkg::*;
#(
    parameter int unsigned DATA_W        = 8,
    parameter int unsigned WORDS_PER_BLK = 64,
    parameter int unsigned LEN_W         = 7,
    parameter int unsigned PTR_W         = 6
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            we_i,
    input  logic [PTR_W-1:0]                waddr_i,
    input  logic [DATA_W-1:0]               wdata_i,
    input  logic                            set_i,
    input  logic [LEN_W-1:0]                set_len_i,
    input  logic                            clr_i,
    output logic                            full_o,
    output logic [LEN_W-1:0]                len_o,
    output logic [DATA_W*WORDS_PER_BLK-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [WORDS_PER_BLK];
    bank_state_t       state_q, state_d;

    // Storage is deliberately not reset; the length mask hides stale words.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        state_d = state_q;
        if (set_i) begin
            state_d.full = 1'b1;
            state_d.len  = KS_LEN_W'(set_len_i);
        end else if (clr_i) begin
            state_d.full = 1'b0;
            state_d.len  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

    assign full_o = state_q.full;
    assign len_o  = state_q.len[LEN_W-1:0];

    always_comb begin
        rdata_o = '0;
        for (int i = 0; i < WORDS_PER_BLK; i++) begin
            if (KS_LEN_W'(i) < state_q.len) begin
                rdata_o[i*DATA_W +: DATA_W] = mem_q[i];
            end
        end
    end

endmodule

// File: rtl/ks_block_collector.sv
// Multi-bank serial-to-block collector feeding the XOR/Poly1305 stage.
// Optional stall counter enabled by KSB_STALL_CNT_EN.
module ks_block_collector
    import ks_buf_pkg::*;
#(
    parameter int unsigned DATA_W        = 8,
    parameter int unsigned WORDS_PER_BLK = 64,
    parameter int unsigned NUM_BANKS     = 2
) (
    input logic                 clk,
    input logic                 rst,
    ks_block_collector_if.slave ks_io
);

    localparam int unsigned LEN_W  = $clog2(WORDS_PER_BLK + 1);
    localparam int unsigned BU_W   = $clog2(NUM_BANKS + 1);
    localparam int unsigned PTR_W  = (WORDS_PER_BLK > 1) ? $clog2(WORDS_PER_BLK) : 1;
    localparam int unsigned BANK_W = $clog2(NUM_BANKS);
    localparam int unsigned BLK_W  = DATA_W * WORDS_PER_BLK;

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [BANK_W-1:0] wr_bank_q, wr_bank_d;
    logic [BANK_W-1:0] rd_bank_q, rd_bank_d;
    logic [BU_W-1:0]   banks_used_q, banks_used_d;

    logic [NUM_BANKS-1:0] full;
    logic [LEN_W-1:0]     bank_len  [NUM_BANKS];
    logic [BLK_W-1:0]     bank_data [NUM_BANKS];

    logic             in_ready, out_valid;
    logic             accept, complete, rd_fire;
    logic [LEN_W-1:0] done_len;

    // Both flags come straight from bank registers, so no path from out_ready to in_ready.
    assign in_ready  = !full[wr_bank_q];
    assign out_valid = full[rd_bank_q];

    always_comb begin
        accept   = ks_io.in_valid && in_ready;
        complete = accept && (ks_io.in_last || (wr_ptr_q == PTR_W'(WORDS_PER_BLK - 1)));
        rd_fire  = out_valid && ks_io.out_ready;
        done_len = LEN_W'(wr_ptr_q) + LEN_W'(1);

        wr_ptr_d  = wr_ptr_q;
        wr_bank_d = wr_bank_q;
        if (complete) begin
            wr_ptr_d  = '0;
            wr_bank_d = BANK_W'(next_bank(32'(wr_bank_q), NUM_BANKS));
        end else if (accept) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end

        rd_bank_d = rd_bank_q;
        if (rd_fire) begin
            rd_bank_d = BANK_W'(next_bank(32'(rd_bank_q), NUM_BANKS));
        end

        banks_used_d = banks_used_q;
        case ({complete, rd_fire})
            2'b10:   banks_used_d = banks_used_q + BU_W'(1);
            2'b01:   banks_used_d = banks_used_q - BU_W'(1);
            default: banks_used_d = banks_used_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            wr_bank_q    <= '0;
            rd_bank_q    <= '0;
            banks_used_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            wr_bank_q    <= wr_bank_d;
            rd_bank_q    <= rd_bank_d;
            banks_used_q <= banks_used_d;
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        ks_buf_bank #(
            .DATA_W       (DATA_W),
            .WORDS_PER_BLK(WORDS_PER_BLK),
            .LEN_W        (LEN_W),
            .PTR_W        (PTR_W)
        ) u_bank (
            .clk      (clk),
            .rst      (rst),
            .we_i     (accept && (wr_bank_q == BANK_W'(b))),
            .waddr_i  (wr_ptr_q),
            .wdata_i  (ks_io.in_data),
            .set_i    (complete && (wr_bank_q == BANK_W'(b))),
            .set_len_i(done_len),
            .clr_i    (rd_fire && (rd_bank_q == BANK_W'(b))),
            .full_o   (full[b]),
            .len_o    (bank_len[b]),
            .rdata_o  (bank_data[b])
        );
    end

    assign ks_io.in_ready   = in_ready;
    assign ks_io.out_valid  = out_valid;
    assign ks_io.out_data   = out_valid ? bank_data[rd_bank_q] : '0;
    assign ks_io.out_len    = out_valid ? bank_len[rd_bank_q] : '0;
    assign ks_io.banks_used = banks_used_q;

`ifdef KSB_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (ks_io.in_valid && !in_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign ks_io.stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ks_block_collector.sv
// Directed bench: a 64x8 / 2-bank collector and a 4x8 / 3-bank collector for pointer wrap.
module tb_ks_block_collector;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ks_block_collector_if #(.DATA_W(8), .WORDS_PER_BLK(64), .NUM_BANKS(2)) bus_a ();
    ks_block_collector_if #(.DATA_W(8), .WORDS_PER_BLK(4), .NUM_BANKS(3))  bus_b ();

    ks_block_collector #(.DATA_W(8), .WORDS_PER_BLK(64), .NUM_BANKS(2)) dut_a (
        .clk  (clk),
        .rst  (rst),
        .ks_io(bus_a)
    );

    ks_block_collector #(.DATA_W(8), .WORDS_PER_BLK(4), .NUM_BANKS(3)) dut_b (
        .clk  (clk),
        .rst  (rst),
        .ks_io(bus_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step_a(input logic v, input logic [7:0] d, input logic l, input logic rdy);
        bus_a.in_valid  = v;
        bus_a.in_data   = d;
        bus_a.in_last   = l;
        bus_a.out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic step_b(input logic v, input logic [7:0] d, input logic l, input logic rdy);
        bus_b.in_valid  = v;
        bus_b.in_data   = d;
        bus_b.in_last   = l;
        bus_b.out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    // Byte i = base + i*incr for i < n, zero above.
    function automatic logic [511:0] fill_blk(input logic [7:0] base, input logic [7:0] incr,
                                              input int n);
        logic [511:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r[i*8 +: 8] = base + 8'(i) * incr;
        return r;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [511:0] e;
        bus_a.in_valid = 1'b0; bus_a.in_data = '0; bus_a.in_last = 1'b0; bus_a.out_ready = 1'b0;
        bus_b.in_valid = 1'b0; bus_b.in_data = '0; bus_b.in_last = 1'b0; bus_b.out_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        chk_eq("rst_in_ready", bus_a.in_ready, 1);
        chk_eq("rst_out_valid", bus_a.out_valid, 0);
        chk_eq("rst_out_len", bus_a.out_len, 0);
        chk_eq("rst_out_data", bus_a.out_data, 0);
        chk_eq("rst_banks_used", bus_a.banks_used, 0);

        // 1: sequential fill, out_valid exactly one cycle after word 63
        for (int i = 0; i < 64; i++) begin
            step_a(1'b1, 8'(i), 1'b0, 1'b1);
            if (i == 62) chk_eq("t1_valid_early", bus_a.out_valid, 0);
        end
        chk_eq("t1_valid", bus_a.out_valid, 1);
        chk_eq("t1_len", bus_a.out_len, 64);
        chk_eq("t1_data", bus_a.out_data, fill_blk(8'h00, 8'h01, 64));
        step_a(1'b0, 8'h00, 1'b0, 1'b1);
        chk_eq("t1_drained", bus_a.out_valid, 0);

        // 2: zeros then repeats
        for (int i = 0; i < 64; i++) step_a(1'b1, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 64; i++) step_a(1'b1, 8'hA5, 1'b0, 1'b0);
        chk_eq("t2_banks_used", bus_a.banks_used, 2);
        chk_eq("t2_len0", bus_a.out_len, 64);
        chk_eq("t2_data0", bus_a.out_data, fill_blk(8'h00, 8'h00, 64));
        step_a(1'b0, 8'h00, 1'b0, 1'b1);
        chk_eq("t2_data1", bus_a.out_data, fill_blk(8'hA5, 8'h00, 64));
        step_a(1'b0, 8'h00, 1'b0, 1'b1);
        chk_eq("t2_empty", bus_a.out_valid, 0);

        // 3: backpressure, 5 blocked cycles, then drain the rest of 200 words
        for (int k = 0; k < 128; k++) begin
            step_a(1'b1, 8'(k), 1'b0, 1'b0);
            if (k == 126) chk_eq("t3_ready_before", bus_a.in_ready, 1);
        end
        chk_eq("t3_ready_low", bus_a.in_ready, 0);
        chk_eq("t3_banks_full", bus_a.banks_used, 2);
        for (int k = 0; k < 4; k++) step_a(1'b1, 8'd128, 1'b0, 1'b0);
        chk_eq("t3_ready_held", bus_a.in_ready, 0);
        step_a(1'b1, 8'd128, 1'b0, 1'b1);
        chk_eq("t3_ready_back", bus_a.in_ready, 1);
        chk_eq("t3_banks_one", bus_a.banks_used, 1);
        chk_eq("t3_data2", bus_a.out_data, fill_blk(8'd64, 8'h01, 64));
        for (int k = 128; k < 200; k++) step_a(1'b1, 8'(k), k == 199, 1'b1);
        chk_eq("t3_tail_len", bus_a.out_len, 8);
        chk_eq("t3_tail_data", bus_a.out_data, fill_blk(8'd192, 8'h01, 8));
        step_a(1'b0, 8'h00, 1'b0, 1'b1);
        chk_eq("t3_banks_zero", bus_a.banks_used, 0);
`ifdef KSB_STALL_CNT_EN
        chk_eq("t3_stall_cnt", bus_a.stall_cnt, 5);
`endif

        // 4: early last, then next block restarts at word 0
        for (int i = 0; i < 10; i++) step_a(1'b1, 8'h11, i == 9, 1'b0);
        chk_eq("t4_valid", bus_a.out_valid, 1);
        chk_eq("t4_len", bus_a.out_len, 10);
        chk_eq("t4_data", bus_a.out_data, fill_blk(8'h11, 8'h00, 10));
        step_a(1'b0, 8'h00, 1'b0, 1'b1);
        step_a(1'b1, 8'h22, 1'b0, 1'b0);
        step_a(1'b1, 8'h33, 1'b0, 1'b0);
        step_a(1'b1, 8'h44, 1'b1, 1'b0);
        e = '0;
        e[23:0] = 24'h443322;
        chk_eq("t4_len3", bus_a.out_len, 3);
        chk_eq("t4_data3", bus_a.out_data, e);
        step_a(1'b0, 8'h00, 1'b0, 1'b1);

        // 5: three banks of 4 words, completion and read together, both pointers wrap
        for (int n = 1; n <= 2; n++)
            for (int j = 0; j < 4; j++) step_b(1'b1, 8'(16 * n + j), 1'b0, 1'b0);
        chk_eq("t5_used2", bus_b.banks_used, 2);
        chk_eq("t5_blk1", bus_b.out_data, fill_blk(8'h10, 8'h01, 4));
        for (int j = 0; j < 4; j++) step_b(1'b1, 8'(8'h30 + j), 1'b0, j == 3);
        chk_eq("t5_used_hold", bus_b.banks_used, 2);
        chk_eq("t5_blk2", bus_b.out_data, fill_blk(8'h20, 8'h01, 4));
        for (int j = 0; j < 4; j++) step_b(1'b1, 8'(8'h40 + j), 1'b0, 1'b0);
        chk_eq("t5_used3", bus_b.banks_used, 3);
        chk_eq("t5_full_ready", bus_b.in_ready, 0);
        step_b(1'b0, 8'h00, 1'b0, 1'b1);
        chk_eq("t5_blk3", bus_b.out_data, fill_blk(8'h30, 8'h01, 4));
        chk_eq("t5_ready_back", bus_b.in_ready, 1);
        step_b(1'b0, 8'h00, 1'b0, 1'b1);
        chk_eq("t5_blk4_wrap", bus_b.out_data, fill_blk(8'h40, 8'h01, 4));
        chk_eq("t5_len4", bus_b.out_len, 4);
        step_b(1'b0, 8'h00, 1'b0, 1'b1);
        chk_eq("t5_empty", bus_b.out_valid, 0);
        chk_eq("t5_used0", bus_b.banks_used, 0);

        // 6: reset with one full bank pending and 37 words in flight
        for (int i = 0; i < 64; i++) step_a(1'b1, 8'hC3, 1'b0, 1'b0);
        for (int i = 0; i < 37; i++) step_a(1'b1, 8'h5A, 1'b0, 1'b0);
        chk_eq("t6_pending", bus_a.banks_used, 1);
        rst = 1'b1;
        step_a(1'b0, 8'h00, 1'b0, 1'b0);
        rst = 1'b0;
        chk_eq("t6_out_valid", bus_a.out_valid, 0);
        chk_eq("t6_in_ready", bus_a.in_ready, 1);
        chk_eq("t6_banks_used", bus_a.banks_used, 0);
        chk_eq("t6_out_len", bus_a.out_len, 0);
`ifdef KSB_STALL_CNT_EN
        chk_eq("t6_stall_cnt", bus_a.stall_cnt, 0);
`endif
        for (int i = 0; i < 64; i++) step_a(1'b1, 8'(i * 3), 1'b0, 1'b0);
        chk_eq("t6_valid", bus_a.out_valid, 1);
        chk_eq("t6_len", bus_a.out_len, 64);
        chk_eq("t6_data", bus_a.out_data, fill_blk(8'h00, 8'h03, 64));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
